// File: rtl/mash111_dsm.sv
// Third-order MASH 1-1-1 delta-sigma modulator for a fractional-N divider.
// Define DSM_DITHER_EN to add a 15-bit LFSR dither on the stage-1 carry-in.
module mash111_dsm #(
  parameter int N     = 16,
  parameter int OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             frac_load,
  input  logic [N-1:0]     frac_in,
  output logic [OUT_W-1:0] dsm_out,
  output logic             dsm_valid,
  output logic [2:0]       carry_dbg
);

  logic [N-1:0]     frac_q, frac_d;
  logic [N-1:0]     acc1_q, acc1_d, acc2_q, acc2_d, acc3_q, acc3_d;
  logic             c2d_q, c2d_d, c3d_q, c3d_d, c3d2_q, c3d2_d;
  logic [OUT_W-1:0] dsm_out_q, dsm_out_d;
  logic             dsm_valid_q, dsm_valid_d;
  logic [2:0]       carry_dbg_q, carry_dbg_d;

  logic             cin;
  logic [N:0]       sum1, sum2, sum3;
  logic             c1, c2, c3;
  logic [OUT_W-1:0] y;

`ifdef DSM_DITHER_EN
  logic [14:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (sync_clr)
      lfsr_d = 15'h0001;
    else if (en)
      lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 15'h0001;
    else     lfsr_q <= lfsr_d;
  end

  assign cin = lfsr_q[0];
`else
  assign cin = 1'b0;
`endif

  always_comb begin
    sum1 = {1'b0, acc1_q} + {1'b0, frac_q} + (N+1)'(cin);
    sum2 = {1'b0, acc2_q} + {1'b0, sum1[N-1:0]};
    sum3 = {1'b0, acc3_q} + {1'b0, sum2[N-1:0]};
    c1   = sum1[N];
    c2   = sum2[N];
    c3   = sum3[N];
    // Modular OUT_W arithmetic yields the two's-complement result directly.
    y    = OUT_W'(c1) + OUT_W'(c2) - OUT_W'(c2d_q)
         + OUT_W'(c3) - (OUT_W'(c3d_q) << 1) + OUT_W'(c3d2_q);
  end

  always_comb begin
    frac_d      = frac_load ? frac_in : frac_q;
    acc1_d      = acc1_q;
    acc2_d      = acc2_q;
    acc3_d      = acc3_q;
    c2d_d       = c2d_q;
    c3d_d       = c3d_q;
    c3d2_d      = c3d2_q;
    dsm_out_d   = dsm_out_q;
    dsm_valid_d = 1'b0;
    carry_dbg_d = carry_dbg_q;
    if (sync_clr) begin
      acc1_d      = '0;
      acc2_d      = '0;
      acc3_d      = '0;
      c2d_d       = 1'b0;
      c3d_d       = 1'b0;
      c3d2_d      = 1'b0;
      dsm_out_d   = '0;
      carry_dbg_d = '0;
    end else if (en) begin
      acc1_d      = sum1[N-1:0];
      acc2_d      = sum2[N-1:0];
      acc3_d      = sum3[N-1:0];
      c2d_d       = c2;
      c3d_d       = c3;
      c3d2_d      = c3d_q;
      dsm_out_d   = y;
      dsm_valid_d = 1'b1;
      carry_dbg_d = {c3, c2, c1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frac_q      <= '0;
      acc1_q      <= '0;
      acc2_q      <= '0;
      acc3_q      <= '0;
      c2d_q       <= 1'b0;
      c3d_q       <= 1'b0;
      c3d2_q      <= 1'b0;
      dsm_out_q   <= '0;
      dsm_valid_q <= 1'b0;
      carry_dbg_q <= '0;
    end else begin
      frac_q      <= frac_d;
      acc1_q      <= acc1_d;
      acc2_q      <= acc2_d;
      acc3_q      <= acc3_d;
      c2d_q       <= c2d_d;
      c3d_q       <= c3d_d;
      c3d2_q      <= c3d2_d;
      dsm_out_q   <= dsm_out_d;
      dsm_valid_q <= dsm_valid_d;
      carry_dbg_q <= carry_dbg_d;
    end
  end

  assign dsm_out   = dsm_out_q;
  assign dsm_valid = dsm_valid_q;
  assign carry_dbg = carry_dbg_q;

endmodule

// File: tb/tb_mash111_dsm.sv
// Self-checking bench for mash111_dsm: directed steps plus random traffic
// against an integer-arithmetic reference of the MASH 1-1-1 rules.
module tb_mash111_dsm;
  localparam int N     = 16;
  localparam int OUT_W = 4;
  localparam int MOD   = 65536;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             sync_clr;
  logic             frac_load;
  logic [N-1:0]     frac_in;
  logic [OUT_W-1:0] dsm_out;
  logic             dsm_valid;
  logic [2:0]       carry_dbg;

  mash111_dsm #(.N(N), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr),
    .frac_load(frac_load), .frac_in(frac_in),
    .dsm_out(dsm_out), .dsm_valid(dsm_valid), .carry_dbg(carry_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference state: plain integers and carry history
  int m_frac, m_acc1, m_acc2, m_acc3;
  int h_c2 [2];   // h[0] = previous step, h[1] = two steps back
  int h_c3 [2];
  int m_out, m_valid, m_dbg, m_lfsr;

  int dut_sum;
  int hist [$];

  function automatic void model_clear(bit keep_frac);
    if (!keep_frac) m_frac = 0;
    m_acc1 = 0; m_acc2 = 0; m_acc3 = 0;
    h_c2[0] = 0; h_c2[1] = 0; h_c3[0] = 0; h_c3[1] = 0;
    m_out = 0; m_valid = 0; m_dbg = 0; m_lfsr = 1;
  endfunction

  function automatic void model_edge(bit e, bit c, bit l, int fin);
    int cin, t, k1, k2, k3;
    if (c) begin
      model_clear(1'b1);
    end else if (e) begin
      cin = 0;
`ifdef DSM_DITHER_EN
      cin = m_lfsr % 2;
      m_lfsr = ((m_lfsr * 2) % 32768) + (((m_lfsr / 16384) + (m_lfsr / 8192)) % 2);
`endif
      t = m_acc1 + m_frac + cin; k1 = t / MOD; m_acc1 = t % MOD;
      t = m_acc2 + m_acc1;       k2 = t / MOD; m_acc2 = t % MOD;
      t = m_acc3 + m_acc2;       k3 = t / MOD; m_acc3 = t % MOD;
      m_out   = k1 + (k2 - h_c2[0]) + (k3 - 2 * h_c3[0] + h_c3[1]);
      h_c2[0] = k2;
      h_c3[1] = h_c3[0];
      h_c3[0] = k3;
      m_valid = 1;
      m_dbg   = 4 * k3 + 2 * k2 + k1;
    end else begin
      m_valid = 0;
    end
    if (l) m_frac = fin;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int out_s();
    return int'($signed(dsm_out));
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, ".out"},   out_s(),        m_out);
    chk({tag, ".valid"}, int'(dsm_valid), m_valid);
    chk({tag, ".dbg"},   int'(carry_dbg), m_dbg);
  endtask

  task automatic cyc(input bit e, input bit c, input bit l, input int fin, input string tag);
    en = e; sync_clr = c; frac_load = l; frac_in = N'(fin);
    @(posedge clk);
    model_edge(e, c, l, fin);
    #1;
    chk_all(tag);
    if (dsm_valid) begin
      dut_sum += out_s();
      hist.push_back(out_s());
    end
  endtask

  task automatic run_steps(input int n, input string tag);
    int lo, hi;
    lo = 0; hi = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 0, tag);
      if (out_s() < -3 || out_s() > 4) begin
        if (lo == 0) lo = out_s();
        hi++;
      end
    end
    chk({tag, ".range_violations"}, hi, 0);
  endtask

  task automatic chk_sum(input string tag, input int exp, input int tol);
    checks++;
    assert (dut_sum >= exp - tol && dut_sum <= exp + tol) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, dut_sum, exp, tol);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sync_clr = 1'b0; frac_load = 1'b0; frac_in = '0;
    model_clear(1'b0);
    #1;
    chk_all("reset");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // T1: zero word produces zero output and no carries
    cyc(1'b0, 1'b0, 1'b1, 0, "t1_load");
    dut_sum = 0;
    for (int i = 0; i < 1000; i++) cyc(1'b1, 1'b0, 1'b0, 0, "t1");
    chk_sum("t1_sum", 0, 0);

    // T2: half-scale word from cleared state, golden first four steps
    cyc(1'b0, 1'b1, 1'b1, 32768, "t2_clr");
    cyc(1'b1, 1'b0, 1'b0, 0, "t2_s1"); chk("t2_y1", out_s(), 0);
    cyc(1'b1, 1'b0, 1'b0, 0, "t2_s2"); chk("t2_y2", out_s(), 2);
    cyc(1'b1, 1'b0, 1'b0, 0, "t2_s3"); chk("t2_y3", out_s(), -1);
    cyc(1'b1, 1'b0, 1'b0, 0, "t2_s4"); chk("t2_y4", out_s(), 1);
    cyc(1'b0, 1'b1, 1'b0, 0, "t2_clr2");
    dut_sum = 0;
    run_steps(8192, "t2_run");
    chk_sum("t2_sum", 4096, 3);

    // T3: full-scale word, range and mean
    cyc(1'b0, 1'b1, 1'b1, 65535, "t3_clr");
    dut_sum = 0;
    run_steps(16384, "t3_run");
    chk_sum("t3_sum", 16383, 3);

    // en low holds output and drops valid
    cyc(1'b0, 1'b0, 1'b0, 0, "hold");

    // T4: load with en uses the old word this step, new word next step
    cyc(1'b0, 1'b1, 1'b1, 32768, "t4_clr");
    cyc(1'b1, 1'b0, 1'b0, 0, "t4_s1");
    cyc(1'b1, 1'b0, 1'b1, 0, "t4_s2");  chk("t4_old_word", out_s(), 2);
    cyc(1'b1, 1'b0, 1'b0, 0, "t4_s3");  chk("t4_new_word", out_s(), -2);

    // random traffic: gaps, loads, occasional clears
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(3, 0) != 0, $urandom_range(199, 0) == 0,
          $urandom_range(31, 0) == 0, int'($urandom_range(65535, 0)), "rand");

    // T5a: async reset between edges clears outputs immediately
    cyc(1'b0, 1'b0, 1'b1, 12345, "t5_load");
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 0, "t5_pre");
    en = 1'b1;
    #3 rst = 1'b1;
    #1;
    model_clear(1'b0);
    chk_all("t5_async");
    @(posedge clk); #1;
    chk_all("t5_held");
    #2 rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 32768, "t5_reload");
    cyc(1'b1, 1'b0, 1'b0, 0, "t5_s1"); chk("t5_y1", out_s(), 0);
    cyc(1'b1, 1'b0, 1'b0, 0, "t5_s2"); chk("t5_y2", out_s(), 2);
    cyc(1'b1, 1'b0, 1'b0, 0, "t5_s3"); chk("t5_y3", out_s(), -1);
    cyc(1'b1, 1'b0, 1'b0, 0, "t5_s4"); chk("t5_y4", out_s(), 1);

    // T5b: sync_clr mid-run beats en, keeps the word
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 0, "t5_mid");
    cyc(1'b1, 1'b1, 1'b0, 0, "t5_sclr");
    cyc(1'b1, 1'b0, 1'b0, 0, "t5c_s1"); chk("t5c_y1", out_s(), 0);
    cyc(1'b1, 1'b0, 1'b0, 0, "t5c_s2"); chk("t5c_y2", out_s(), 2);
    cyc(1'b1, 1'b0, 1'b0, 0, "t5c_s3"); chk("t5c_y3", out_s(), -1);
    cyc(1'b1, 1'b0, 1'b0, 0, "t5c_s4"); chk("t5c_y4", out_s(), 1);

`ifdef DSM_DITHER_EN
    // T6: dithered quarter-scale word, mean and aperiodicity
    begin
      int diffs;
      cyc(1'b0, 1'b1, 1'b1, 16384, "t6_clr");
      dut_sum = 0;
      hist.delete();
      run_steps(16384, "t6_run");
      chk_sum("t6_sum", 4096, 4);
      diffs = 0;
      for (int i = 0; i + 4 < hist.size(); i++)
        if (hist[i] != hist[i+4]) diffs++;
      checks++;
      assert (diffs > 0) else begin
        errors++;
        $error("FAIL t6_aperiodic observed=%0d expected=>0", diffs);
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
